// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker
// Avalon-MM master that reads the system ID slave (address 0 = ID word,
// address 1 = timestamp word) after reset or on a start pulse, compares both
// words against the build-time values and reports the result to boot logic.
// Optional feature macro: SYSID_CHECK_RETRY_EN -- when defined, a mismatching
// check is re-run up to MAX_RETRIES times before the result is reported.

module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1346452407,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [1:0]  retries
);

  // The abort fires in the cycle where the stall counter already holds
  // TIMEOUT_CYCLES-1 and the slave is still stalling.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  // The retry counter is two bits wide, so larger limits saturate at 3.
  localparam logic [1:0] RetryLimit = (MAX_RETRIES > 32'd3) ? 2'd3 : 2'(MAX_RETRIES);

`ifdef SYSID_CHECK_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4,
    TOUT  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] waitCnt_q, waitCnt_d;
  logic [31:0] idWord_q, idWord_d;
  logic [31:0] tsWord_q, tsWord_d;
  logic        idMatch_q, idMatch_d;
  logic        tsMatch_q, tsMatch_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  retries_q, retries_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        idEqual, tsEqual;

  assign idEqual = (idWord_q == EXPECTED_ID);
  assign tsEqual = (tsWord_q == EXPECTED_TIMESTAMP);

  // Next-state, capture and status decisions for the check sequence.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    idWord_d  = idWord_q;
    tsWord_d  = tsWord_q;
    idMatch_d = idMatch_q;
    tsMatch_d = tsMatch_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    retries_d = retries_q;

    case (state_q)
      IDLE: begin
        if (AUTO_START || start) begin
          state_d   = RD_ID;
          waitCnt_d = '0;
        end
      end

      RD_ID: begin
        if (!avm_waitrequest) begin
          idWord_d  = avm_readdata;
          state_d   = RD_TS;
          waitCnt_d = '0;
        end else if (waitCnt_q == TimeoutLast) begin
          state_d   = TOUT;
          idMatch_d = 1'b0;
          tsMatch_d = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          tsWord_d = avm_readdata;
          state_d  = CMP;
        end else if (waitCnt_q == TimeoutLast) begin
          state_d   = TOUT;
          idMatch_d = 1'b0;
          tsMatch_d = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end

      CMP: begin
        idMatch_d = idEqual;
        tsMatch_d = tsEqual;
        pass_d    = idEqual && tsEqual;
        if (RetryEn && !(idEqual && tsEqual) && (retries_q < RetryLimit)) begin
          retries_d = retries_q + 2'd1;
          state_d   = RD_ID;
          waitCnt_d = '0;
        end else begin
          state_d = DONE;
        end
      end

      DONE, TOUT: begin
        if (start) begin
          idMatch_d = 1'b0;
          tsMatch_d = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          retries_d = '0;
          state_d   = RD_ID;
          waitCnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CMP);
    done_d = (state_d == DONE) || (state_d == TOUT);
  end

  // State register, stall counter and the two captured slave words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      idWord_q  <= '0;
      tsWord_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      idWord_q  <= idWord_d;
      tsWord_q  <= tsWord_d;
    end
  end

  // Registered status flags seen by boot logic and the LEDs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idMatch_q <= 1'b0;
      tsMatch_q <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      retries_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idMatch_q <= idMatch_d;
      tsMatch_q <= tsMatch_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      retries_q <= retries_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Bus strobes come straight from the state register, so an asynchronous
  // reset drops the read at once and the address cannot glitch mid-stall.
  assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm_address = (state_q == RD_TS);

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_match = idMatch_q;
  assign ts_match = tsMatch_q;
  assign timeout  = timeout_q;
  assign retries  = RetryEn ? retries_q : 2'd0;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Testbench for nios_system_sysid_checker (default build, retry feature off).
// A behavioural sysid slave answers reads with configurable stall counts; the
// expected completion edge, flags and read sequence come from a small
// arithmetic model of the check rules.

module tb_nios_system_sysid_checker;

  localparam logic [31:0] ExpId = 32'd0;
  localparam logic [31:0] ExpTs = 32'd1346452407;
  localparam int          Tout  = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        pass;
  logic        id_match;
  logic        ts_match;
  logic        timeout;
  logic [1:0]  retries;

  int totalCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clock = ~clock;

  nios_system_sysid_checker #(
    .EXPECTED_ID       (ExpId),
    .EXPECTED_TIMESTAMP(ExpTs),
    .AUTO_START        (1'b1),
    .TIMEOUT_CYCLES    (Tout),
    .MAX_RETRIES       (3)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_match       (id_match),
    .ts_match       (ts_match),
    .timeout        (timeout),
    .retries        (retries)
  );

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drops reset between clock edges, checks every output cleared without an
  // edge, then releases reset on the next falling edge.
  task automatic pulseResetAndCheck(input string tag);
    #2 reset_n = 1'b0;
    #1;
    checkOutput({tag, ".avm_read"}, 32'(avm_read), 32'd0);
    checkOutput({tag, ".busy"},     32'(busy),     32'd0);
    checkOutput({tag, ".done"},     32'(done),     32'd0);
    checkOutput({tag, ".pass"},     32'(pass),     32'd0);
    checkOutput({tag, ".id_match"}, 32'(id_match), 32'd0);
    checkOutput({tag, ".ts_match"}, 32'(ts_match), 32'd0);
    checkOutput({tag, ".timeout"},  32'(timeout),  32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Runs one full check from a falling edge: optionally pulses start, plays
  // the slave with the given stalls and words, then compares the outcome
  // against the model. Edge 1 is the edge that leaves IDLE/DONE/TOUT.
  task automatic applyStimulus(input string tag, input logic [31:0] idWord,
                               input logic [31:0] tsWord, input int stallId,
                               input int stallTs, input bit useStart,
                               input bit noisyStart);
    int  stallLeft [2];
    int  readOrder [$];
    int  edgeCount;
    int  doneEdge;
    int  expEdge;
    int  expReads;
    int  idx;
    int  prevAddr;
    bit  prevStall;
    bit  addrStable;
    bit  expTout;
    bit  expIdm;
    bit  expTsm;

    expIdm = (idWord == ExpId);
    expTsm = (tsWord == ExpTs);
    if (stallId >= Tout) begin
      expTout  = 1'b1;
      expEdge  = Tout + 1;
      expReads = 0;
    end else if (stallTs >= Tout) begin
      expTout  = 1'b1;
      expEdge  = stallId + 2 + Tout;
      expReads = 1;
    end else begin
      expTout  = 1'b0;
      expEdge  = stallId + stallTs + 4;
      expReads = 2;
    end

    stallLeft[0] = stallId;
    stallLeft[1] = stallTs;
    readOrder.delete();
    edgeCount  = 0;
    doneEdge   = 0;
    prevAddr   = 0;
    prevStall  = 1'b0;
    addrStable = 1'b1;
    if (useStart) start = 1'b1;

    while (doneEdge == 0 && edgeCount < 400) begin
      @(posedge clock);
      edgeCount++;
      @(negedge clock);
      start = 1'b0;
      if (edgeCount == 1) checkOutput({tag, ".busyAtEdge1"}, 32'(busy), 32'd1);
      if (prevStall && avm_read && (int'(avm_address) != prevAddr)) addrStable = 1'b0;
      if (done) doneEdge = edgeCount;
      prevStall = 1'b0;
      if (avm_read) begin
        idx      = avm_address ? 1 : 0;
        prevAddr = idx;
        if (stallLeft[idx] > 0) begin
          avm_waitrequest = 1'b1;
          avm_readdata    = $urandom;
          stallLeft[idx]--;
          prevStall = 1'b1;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata    = (idx == 1) ? tsWord : idWord;
          readOrder.push_back(idx);
        end
      end else begin
        avm_waitrequest = 1'($urandom);
        avm_readdata    = $urandom;
      end
      if (noisyStart && busy && !done) start = 1'($urandom_range(0, 1));
    end

    checkOutput({tag, ".doneEdge"},  32'(doneEdge),           32'(expEdge));
    checkOutput({tag, ".pass"},      32'(pass),               32'(!expTout && expIdm && expTsm));
    checkOutput({tag, ".id_match"},  32'(id_match),           32'(!expTout && expIdm));
    checkOutput({tag, ".ts_match"},  32'(ts_match),           32'(!expTout && expTsm));
    checkOutput({tag, ".timeout"},   32'(timeout),            32'(expTout));
    checkOutput({tag, ".busy"},      32'(busy),               32'd0);
    checkOutput({tag, ".avm_read"},  32'(avm_read),           32'd0);
    checkOutput({tag, ".retries"},   32'(retries),            32'd0);
    checkOutput({tag, ".readCount"}, 32'(readOrder.size()),   32'(expReads));
    checkOutput({tag, ".addrStable"}, 32'(addrStable),        32'd1);
    if (readOrder.size() >= 1) checkOutput({tag, ".firstAddr"},  32'(readOrder[0]), 32'd0);
    if (readOrder.size() >= 2) checkOutput({tag, ".secondAddr"}, 32'(readOrder[1]), 32'd1);

    // done must hold until the next start
    @(posedge clock);
    @(negedge clock);
    checkOutput({tag, ".doneHeld"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] rId;
    logic [31:0] rTs;
    int          sId;
    int          sTs;

    reset_n         = 1'b1;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] checking reset state");
    checkOutput("reset.avm_read", 32'(avm_read), 32'd0);
    checkOutput("reset.busy",     32'(busy),     32'd0);
    checkOutput("reset.done",     32'(done),     32'd0);
    checkOutput("reset.pass",     32'(pass),     32'd0);
    checkOutput("reset.timeout",  32'(timeout),  32'd0);
    checkOutput("reset.retries",  32'(retries),  32'd0);
    reset_n = 1'b1;

    $display("[TB] directed checks");
    applyStimulus("autoPass",  ExpId,          ExpTs,         0,    0,  1'b0, 1'b0);
    applyStimulus("tsWrong",   ExpId,          ExpTs + 32'd1, 0,    0,  1'b1, 1'b0);
    applyStimulus("stall3",    ExpId,          ExpTs,         3,    3,  1'b1, 1'b0);
    applyStimulus("idStuck",   ExpId,          ExpTs,         1000, 0,  1'b1, 1'b0);
    applyStimulus("afterTout", ExpId,          ExpTs,         0,    0,  1'b1, 1'b0);
    applyStimulus("idStall15", ExpId,          ExpTs,         15,   2,  1'b1, 1'b0);
    applyStimulus("tsStall15", ExpId,          ExpTs,         1,    15, 1'b1, 1'b0);
    applyStimulus("tsStall16", ExpId,          ExpTs,         2,    16, 1'b1, 1'b0);
    applyStimulus("idWrong",   32'h0000_1234,  ExpTs,         0,    0,  1'b1, 1'b0);
    applyStimulus("bothWrong", 32'hdead_beef,  32'h0,         1,    0,  1'b1, 1'b0);

    $display("[TB] asynchronous reset while holding a pass result");
    applyStimulus("preReset",  ExpId, ExpTs, 0, 1, 1'b1, 1'b0);
    pulseResetAndCheck("resetInDone");
    applyStimulus("postReset", ExpId, ExpTs, 0, 0, 1'b0, 1'b0);

    $display("[TB] randomized checks");
    for (int i = 0; i < 12; i++) begin
      rId = ($urandom_range(0, 1) == 1) ? ExpId : $urandom;
      rTs = ($urandom_range(0, 1) == 1) ? ExpTs : $urandom;
      sId = ($urandom_range(0, 7) == 0) ? Tout + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 6));
      sTs = ($urandom_range(0, 7) == 0) ? Tout + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 6));
      applyStimulus($sformatf("rand%0d", i), rId, rTs, sId, sTs, 1'b1, 1'b1);
    end

    $display("[TB] asynchronous reset during the timestamp read");
    start = 1'b1;
    @(negedge clock);
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = ExpId;
    @(negedge clock);
    checkOutput("midTs.avm_address", 32'(avm_address), 32'd1);
    checkOutput("midTs.avm_read",    32'(avm_read),    32'd1);
    checkOutput("midTs.busy",        32'(busy),        32'd1);
    avm_waitrequest = 1'b1;
    avm_readdata    = $urandom;
    pulseResetAndCheck("resetInRdTs");
    applyStimulus("afterMidReset", ExpId, ExpTs, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
